// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO bus of the FIFO write arbiter.
// Handshake: a word moves from requester k when ivalid[k] and oready[k] are
// both high in the same cycle. ivalid may rise independently of oready.
// While ivalid[k] is high and oready[k] is low, the requester holds idata
// and ilast stable. oready is low for every requester that does not hold
// the grant, and also while ififo_full is high.
`timescale 1ns/1ps
interface fifo_wr_arbiter_if #(
  parameter int pBITS = 8,
  parameter int pREQ  = 4
);
  logic [pREQ-1:0]       ireq;
  logic [pREQ-1:0]       ivalid;
  logic [pREQ-1:0]       ilast;
  logic [pREQ*pBITS-1:0] idata;
  logic                  ififo_full;
  logic                  ofifo_wr;
  logic [pBITS-1:0]      ofifo_data;
  logic [pREQ-1:0]       ogrant;
  logic [pREQ-1:0]       oready;
  logic                  oabort;
  logic [15:0]           opkt_cnt;

  // Requesters and the FIFO side (the environment around the arbiter)
  modport master (
    output ireq, ivalid, ilast, idata, ififo_full,
    input  ofifo_wr, ofifo_data, ogrant, oready, oabort, opkt_cnt
  );

  // The arbiter itself
  modport slave (
    input  ireq, ivalid, ilast, idata, ififo_full,
    output ofifo_wr, ofifo_data, ogrant, oready, oabort, opkt_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter in front of a single FIFO write port.
// A requester is locked for a whole packet; the packet ends on ilast or
// after pMAX_LEN words (forced end, flagged by a one-cycle oabort).
`timescale 1ns/1ps
module fifo_wr_arbiter #(
  parameter int pBITS    = 8,
  parameter int pREQ     = 4,
  parameter int pMAX_LEN = 64
) (
  input  logic              iclk,
  input  logic              ireset_n,
  fifo_wr_arbiter_if.slave  bus,
  output logic              ostate    // 0 = IDLE, 1 = LOCK
);

  localparam int IDX_W = (pREQ > 1) ? $clog2(pREQ) : 1;
  localparam int CNT_W = $clog2(pMAX_LEN + 1);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t           state, stateNext;
  logic [IDX_W-1:0] lastGnt;
  logic [IDX_W-1:0] gntIdx;
  logic [IDX_W-1:0] pickIdx;
  logic             pickValid;
  logic [pREQ-1:0]  grant;
  logic [CNT_W-1:0] wordCnt;
  logic [15:0]      pktCnt;
  logic             abortQ;
  logic             xfer;
  logic             isLast;
  logic             atMax;
  logic             pktEnd;
  logic             forcedEnd;
  int               cand;

  // Round-robin pick: the nearest requester after the last granted one wins.
  // The loop runs from the farthest candidate down so the nearest overrides.
  always_comb begin
    pickIdx   = lastGnt;
    pickValid = 1'b0;
    cand      = 0;
    for (int i = pREQ; i >= 1; i--) begin
      cand = (int'(lastGnt) + i) % pREQ;
      if (bus.ireq[cand]) begin
        pickIdx   = IDX_W'(cand);
        pickValid = 1'b1;
      end
    end
  end

  // Transfer qualification and end-of-packet detection for the locked requester
  always_comb begin
    xfer      = (state == LOCK) && bus.ivalid[gntIdx] && !bus.ififo_full;
    isLast    = bus.ilast[gntIdx];
    atMax     = (wordCnt == CNT_W'(pMAX_LEN - 1));
    pktEnd    = xfer && (isLast || atMax);
    forcedEnd = xfer && !isLast && atMax;
  end

  // FSM state register
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) state <= IDLE;
    else           state <= stateNext;
  end

  // FSM next state: lock on any request, release on end of packet
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (pickValid) stateNext = LOCK;
      LOCK:    if (pktEnd)    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Grant, word counter, packet counter and abort pulse
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      grant   <= '0;
      gntIdx  <= '0;
      lastGnt <= IDX_W'(pREQ - 1);
      wordCnt <= '0;
      pktCnt  <= '0;
      abortQ  <= 1'b0;
    end else begin
      abortQ <= forcedEnd;
      if (state == IDLE) begin
        if (pickValid) begin
          grant   <= {{(pREQ-1){1'b0}}, 1'b1} << pickIdx;
          gntIdx  <= pickIdx;
          wordCnt <= '0;
        end
      end else begin
        if (xfer) wordCnt <= wordCnt + 1'b1;
        if (pktEnd) begin
          grant   <= '0;
          lastGnt <= gntIdx;
          pktCnt  <= pktCnt + 16'd1;
        end
      end
    end
  end

  assign bus.ogrant     = grant;
  assign bus.oready     = ((state == LOCK) && !bus.ififo_full) ? grant : '0;
  assign bus.ofifo_wr   = xfer;
  assign bus.ofifo_data = xfer ? bus.idata[gntIdx*pBITS +: pBITS] : '0;
  assign bus.oabort     = abortQ;
  assign bus.opkt_cnt   = pktCnt;
  assign ostate         = (state == LOCK);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: table of per-cycle vectors for the round-robin
// sweep, then hand-written sequences for stall, lock hold, forced end and reset.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

  logic iclk;
  logic ireset_n;
  logic state_dbg;

  fifo_wr_arbiter_if #(.pBITS(8), .pREQ(4)) bus ();

  fifo_wr_arbiter #(.pBITS(8), .pREQ(4), .pMAX_LEN(64)) dut (
    .iclk     (iclk),
    .ireset_n (ireset_n),
    .bus      (bus.slave),
    .ostate   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- counters and scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic sb_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every FIFO write must match the oldest expected word
  always @(negedge iclk) begin
    if (sb_en && bus.ofifo_wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_extra: unexpected write data %0h at %0t", bus.ofifo_data, $time);
      end else begin
        chk("sb_data", {24'd0, bus.ofifo_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] r, input logic [3:0] v, input logic [3:0] l,
                       input logic [31:0] d, input logic f);
    bus.ireq       = r;
    bus.ivalid     = v;
    bus.ilast      = l;
    bus.idata      = d;
    bus.ififo_full = f;
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  function automatic logic [31:0] mk_data(input int p, input int w);
    logic [31:0] d;
    for (int k = 0; k < 4; k++) d[k*8 +: 8] = 8'(p*16 + k*4 + w);
    return d;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  req;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        full;
    logic        exp_wr;
    logic [7:0]  exp_data;
    logic [3:0]  exp_grant;
    logic [3:0]  exp_ready;
    logic        exp_abort;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // Five 2-word packets with every requester asking: grants 0,1,2,3,0,
    // each packet preceded by one IDLE cycle with ogrant=0.
    for (int p = 0; p < 5; p++) begin
      int g;
      g = p % 4;
      vecs[p*3]   = '{4'b1111, 4'b0000, 4'b0000, 32'd0, 1'b0,
                      1'b0, 8'd0, 4'b0000, 4'b0000, 1'b0, 16'(p)};
      vecs[p*3+1] = '{4'b1111, 4'b1111, 4'b0000, mk_data(p, 0), 1'b0,
                      1'b1, 8'(p*16 + g*4), 4'(1 << g), 4'(1 << g), 1'b0, 16'(p)};
      vecs[p*3+2] = '{4'b1111, 4'b1111, 4'b1111, mk_data(p, 1), 1'b0,
                      1'b1, 8'(p*16 + g*4 + 1), 4'(1 << g), 4'(1 << g), 1'b0, 16'(p)};
    end

    // ---- reset values ----
    ireset_n = 1'b0;
    drive(4'b0, 4'b0, 4'b0, 32'd0, 1'b0);
    repeat (2) @(posedge iclk);
    #1;
    chk("rst_grant", {28'd0, bus.ogrant}, 32'd0);
    chk("rst_ready", {28'd0, bus.oready}, 32'd0);
    chk("rst_wr",    {31'd0, bus.ofifo_wr}, 32'd0);
    chk("rst_abort", {31'd0, bus.oabort}, 32'd0);
    chk("rst_cnt",   {16'd0, bus.opkt_cnt}, 32'd0);
    chk("rst_state", {31'd0, state_dbg}, 32'd0);
    ireset_n = 1'b1;

    // ---- table sweep ----
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].req, vecs[i].valid, vecs[i].last, vecs[i].data, vecs[i].full);
      #1;
      chk("tbl_wr",    {31'd0, bus.ofifo_wr}, {31'd0, vecs[i].exp_wr});
      if (vecs[i].exp_wr)
        chk("tbl_data", {24'd0, bus.ofifo_data}, {24'd0, vecs[i].exp_data});
      chk("tbl_grant", {28'd0, bus.ogrant}, {28'd0, vecs[i].exp_grant});
      chk("tbl_ready", {28'd0, bus.oready}, {28'd0, vecs[i].exp_ready});
      chk("tbl_abort", {31'd0, bus.oabort}, {31'd0, vecs[i].exp_abort});
      chk("tbl_cnt",   {16'd0, bus.opkt_cnt}, {16'd0, vecs[i].exp_cnt});
      tick();
    end
    drive(4'b0, 4'b0, 4'b0, 32'd0, 1'b0);
    #1;
    chk("sweep_cnt",   {16'd0, bus.opkt_cnt}, 32'd5);
    chk("sweep_grant", {28'd0, bus.ogrant}, 32'd0);

    sb_en = 1'b1;

    // ---- stall: requester 2, FIFO full for 3 cycles mid-packet ----
    drive(4'b0100, 4'b0, 4'b0, 32'd0, 1'b0);
    #1; chk("stall_idle_grant", {28'd0, bus.ogrant}, 32'd0);
    tick();
    chk("stall_grant", {28'd0, bus.ogrant}, 32'b0100);
    drive(4'b0000, 4'b0100, 4'b0, {8'h00, 8'hA0, 16'h0}, 1'b0);
    exp_q.push_back(8'hA0);
    #1; chk("stall_w0_wr", {31'd0, bus.ofifo_wr}, 32'd1);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(4'b0000, 4'b0100, 4'b0, {8'h00, 8'hA1, 16'h0}, 1'b1);
      #1;
      chk("stall_ready", {28'd0, bus.oready}, 32'd0);
      chk("stall_wr",    {31'd0, bus.ofifo_wr}, 32'd0);
      tick();
    end
    drive(4'b0000, 4'b0100, 4'b0, {8'h00, 8'hA1, 16'h0}, 1'b0);
    exp_q.push_back(8'hA1);
    #1; chk("stall_resume_ready", {28'd0, bus.oready}, 32'b0100);
    tick();
    drive(4'b0000, 4'b0100, 4'b0, {8'h00, 8'hA2, 16'h0}, 1'b0);
    exp_q.push_back(8'hA2);
    tick();
    drive(4'b0000, 4'b0100, 4'b0100, {8'h00, 8'hA3, 16'h0}, 1'b0);
    exp_q.push_back(8'hA3);
    tick();
    drive(4'b0, 4'b0, 4'b0, 32'd0, 1'b0);
    #1;
    chk("stall_cnt",   {16'd0, bus.opkt_cnt}, 32'd6);
    chk("stall_grant_end", {28'd0, bus.ogrant}, 32'd0);
    chk("stall_sb_empty", exp_q.size(), 32'd0);

    // ---- lock hold: ireq[0] drops, ireq[3] rises; foreign valid/last ignored ----
    drive(4'b0001, 4'b0, 4'b0, 32'd0, 1'b0);
    tick();
    chk("hold_grant0", {28'd0, bus.ogrant}, 32'b0001);
    drive(4'b1000, 4'b0001, 4'b0, {24'h0, 8'hB0}, 1'b0);
    exp_q.push_back(8'hB0);
    tick();
    drive(4'b1000, 4'b0010, 4'b0010, {16'h0, 8'hEE, 8'h00}, 1'b0);
    #1;
    chk("foreign_wr",    {31'd0, bus.ofifo_wr}, 32'd0);
    chk("foreign_ready", {28'd0, bus.oready}, 32'b0001);
    tick();
    chk("foreign_grant", {28'd0, bus.ogrant}, 32'b0001);
    chk("foreign_state", {31'd0, state_dbg}, 32'd1);
    drive(4'b1000, 4'b0001, 4'b0001, {24'h0, 8'hB1}, 1'b0);
    exp_q.push_back(8'hB1);
    #1; chk("hold_grant_last", {28'd0, bus.ogrant}, 32'b0001);
    tick();
    drive(4'b1000, 4'b0, 4'b0, 32'd0, 1'b0);
    #1;
    chk("hold_idle_grant", {28'd0, bus.ogrant}, 32'd0);
    chk("hold_idle_state", {31'd0, state_dbg}, 32'd0);
    tick();
    chk("hold_next_grant", {28'd0, bus.ogrant}, 32'b1000);
    drive(4'b0000, 4'b1000, 4'b1000, {8'hC0, 24'h0}, 1'b0);
    exp_q.push_back(8'hC0);
    tick();
    drive(4'b0, 4'b0, 4'b0, 32'd0, 1'b0);
    #1; chk("hold_cnt", {16'd0, bus.opkt_cnt}, 32'd8);

    // ---- forced end: requester 1 sends 70 words without ilast ----
    for (int i = 0; i < 70; i++) begin
      logic       e_wr;
      logic [3:0] e_gnt;
      drive(4'b0110, 4'b0010, 4'b0, {16'h0, 8'(i), 8'h00}, 1'b0);
      e_wr  = (i >= 1 && i <= 64);
      e_gnt = (i == 0 || i == 65) ? 4'b0000 : (i <= 64) ? 4'b0010 : 4'b0100;
      if (e_wr) exp_q.push_back(8'(i));
      #1;
      chk("max_wr",    {31'd0, bus.ofifo_wr}, {31'd0, e_wr});
      chk("max_abort", {31'd0, bus.oabort}, {31'd0, (i == 65)});
      chk("max_grant", {28'd0, bus.ogrant}, {28'd0, e_gnt});
      if (i == 65) chk("max_cnt", {16'd0, bus.opkt_cnt}, 32'd9);
      tick();
    end
    drive(4'b0000, 4'b0100, 4'b0100, {8'h00, 8'h5A, 16'h0}, 1'b0);
    exp_q.push_back(8'h5A);
    #1; chk("max_next_wr", {31'd0, bus.ofifo_wr}, 32'd1);
    tick();
    drive(4'b0, 4'b0, 4'b0, 32'd0, 1'b0);
    #1;
    chk("max_cnt_end", {16'd0, bus.opkt_cnt}, 32'd10);
    chk("max_sb_empty", exp_q.size(), 32'd0);

    // ---- asynchronous reset during word 3 ----
    drive(4'b0010, 4'b0, 4'b0, 32'd0, 1'b0);
    tick();
    chk("rstmid_grant", {28'd0, bus.ogrant}, 32'b0010);
    drive(4'b0000, 4'b0010, 4'b0, {16'h0, 8'hD0, 8'h0}, 1'b0);
    exp_q.push_back(8'hD0);
    tick();
    drive(4'b0000, 4'b0010, 4'b0, {16'h0, 8'hD1, 8'h0}, 1'b0);
    exp_q.push_back(8'hD1);
    tick();
    drive(4'b0000, 4'b0010, 4'b0, {16'h0, 8'hD2, 8'h0}, 1'b0);
    #2;
    ireset_n = 1'b0;
    #1;
    chk("rstmid_wr",    {31'd0, bus.ofifo_wr}, 32'd0);
    chk("rstmid_grant0", {28'd0, bus.ogrant}, 32'd0);
    chk("rstmid_ready", {28'd0, bus.oready}, 32'd0);
    chk("rstmid_cnt",   {16'd0, bus.opkt_cnt}, 32'd0);
    chk("rstmid_state", {31'd0, state_dbg}, 32'd0);
    drive(4'b1111, 4'b0, 4'b0, 32'd0, 1'b0);
    @(negedge iclk);
    #1;
    ireset_n = 1'b1;
    tick();
    chk("rstmid_first_grant", {28'd0, bus.ogrant}, 32'b0001);
    chk("rstmid_cnt_after",   {16'd0, bus.opkt_cnt}, 32'd0);

    // ---- single persistent requester is re-granted after one IDLE cycle ----
    drive(4'b0001, 4'b0001, 4'b0001, {24'h0, 8'h77}, 1'b0);
    exp_q.push_back(8'h77);
    tick();
    drive(4'b0001, 4'b0, 4'b0, 32'd0, 1'b0);
    #1;
    chk("solo_idle_grant", {28'd0, bus.ogrant}, 32'd0);
    chk("solo_cnt", {16'd0, bus.opkt_cnt}, 32'd1);
    tick();
    chk("solo_regrant", {28'd0, bus.ogrant}, 32'b0001);
    drive(4'b0000, 4'b0001, 4'b0001, {24'h0, 8'h78}, 1'b0);
    exp_q.push_back(8'h78);
    tick();
    drive(4'b0, 4'b0, 4'b0, 32'd0, 1'b0);
    tick();
    chk("final_cnt", {16'd0, bus.opkt_cnt}, 32'd2);
    chk("final_sb_empty", exp_q.size(), 32'd0);

    // ---- report ----
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
